// File: rtl/mem_system_if.sv
// mem_system_if: CPU memory port plus the output FIFO drain stream.
interface mem_system_if;
  logic [31:0] MemAddress;
  logic [31:0] MemWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] MemReadData;
  logic [31:0] OutData;
  logic        OutValid;
  logic        OutReady;
  logic        Fault;
  modport master (
    output MemAddress, MemWriteData, MemRead, MemWrite, OutReady,
    input  MemReadData, OutData, OutValid, Fault
  );
  modport slave (
    input  MemAddress, MemWriteData, MemRead, MemWrite, OutReady,
    output MemReadData, OutData, OutValid, Fault
  );
endinterface

// File: rtl/mem_system.sv
// mem_system: word RAM plus I/O page (output FIFO, STATUS) behind the CPU memory port.
// Defining MEM_SYS_CYCLE_COUNTER_EN adds the CYCLE counter at 0xFFFF0008.
module mem_system #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input logic         Clk,
  input logic         Rst,
  mem_system_if.slave bus
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [31:0] ram [RAM_WORDS];
  logic [31:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, fault_q, fault_d;
  logic io, sel_ram, sel_out, sel_stat, sel_cyc, ok;
  logic full, empty, push_req, push, pop, stat_wr, ram_we, fifo_we;
  logic [31:0] status, cyc_val;
  assign io       = bus.MemAddress[31:16] == 16'hFFFF;
  assign sel_ram  = !io && bus.MemAddress[31:AW+2] == '0;
  assign sel_out  = io && bus.MemAddress[15:0] == 16'h0;
  assign sel_stat = io && bus.MemAddress[15:0] == 16'h4;
  assign ok       = bus.MemAddress[1:0] == 2'b0 && (sel_ram || sel_out || sel_stat || sel_cyc);
`ifdef MEM_SYS_CYCLE_COUNTER_EN
  logic [31:0] cyc_q, cyc_d;
  assign sel_cyc = io && bus.MemAddress[15:0] == 16'h8;
  assign cyc_val = cyc_q;
  assign cyc_d   = (bus.MemWrite && ok && sel_cyc) ? bus.MemWriteData : cyc_q + 32'd1;
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) cyc_q <= '0;
    else cyc_q <= cyc_d;
`else
  assign sel_cyc = 1'b0;
  assign cyc_val = '0;
`endif
  assign empty    = cnt_q == '0;
  assign full     = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign pop      = !empty && bus.OutReady;
  assign push_req = bus.MemWrite && ok && sel_out;
  // a push into a full FIFO still lands when the head leaves on the same edge
  assign push     = push_req && (!full || pop);
  assign stat_wr  = bus.MemWrite && ok && sel_stat;
  assign wr_d     = push ? wr_q + PW'(1) : wr_q;
  assign rd_d     = pop ? rd_q + PW'(1) : rd_q;
  assign cnt_d    = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign ovf_d    = (push_req && full && !pop) || (ovf_q && !(stat_wr && bus.MemWriteData[8]));
  assign fault_d  = ((bus.MemRead || bus.MemWrite) && !ok) || (fault_q && !(stat_wr && bus.MemWriteData[9]));
  assign status   = {22'b0, fault_q, ovf_q, 5'(cnt_q), 1'b0, full, empty};
  assign ram_we   = Rst && bus.MemWrite && ok && sel_ram;
  assign fifo_we  = Rst && push;
  assign bus.MemReadData = !(bus.MemRead && ok) ? '0 :
                           sel_ram  ? ram[bus.MemAddress[AW+1:2]] :
                           sel_stat ? status :
                           sel_cyc  ? cyc_val : '0;
  assign bus.OutValid = !empty;
  assign bus.OutData  = empty ? '0 : fifo[rd_q];
  assign bus.Fault    = fault_q;
  always_ff @(posedge Clk) begin
    if (ram_we) ram[bus.MemAddress[AW+1:2]] <= bus.MemWriteData;
    if (fifo_we) fifo[wr_q] <= bus.MemWriteData;
  end
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      fault_q <= fault_d;
    end
endmodule
